// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and the stall/flush/
// forward controls plus status returned by the controller.
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D;
    logic [4:0]           Rs2D;
    logic [4:0]           Rs1E;
    logic [4:0]           Rs2E;
    logic [4:0]           RdE;
    logic [4:0]           RdM;
    logic [4:0]           RdW;
    logic [1:0]           ResultSrcE;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 PCSrcE;
    logic                 MemReqM;
    logic                 MemReadyM;
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 StallM;
    logic                 FlushD;
    logic                 FlushE;
    logic                 FlushW;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic                 MemErr;
    logic [CNT_WIDTH-1:0] StallCycles;
    logic [CNT_WIDTH-1:0] FlushEvents;

    // Pipeline side: supplies hazard information, consumes controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
        output RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, MemErr, StallCycles, FlushEvents
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
        input  RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, MemErr, StallCycles, FlushEvents
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32 hazard controller: forwarding selects, load-use and
// redirect handling, data-memory wait freeze with a timeout watchdog, and
// two saturating performance counters.
module hazard_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ERROR = 2'b10
    } state_e;

    // The wait counter holds the number of consecutive wait cycles already
    // seen before the current one (RUN seeds it with 1 on entry to WAIT), so
    // the timeout fires on the MEM_TIMEOUT-th wait cycle. With a timeout of
    // one the earliest possible firing is the first WAIT cycle (count 1).
    localparam int             WCW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] FIRE_AT = WCW'((MEM_TIMEOUT > 1) ? (MEM_TIMEOUT - 1) : 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                 mem_err_q, mem_err_d;
    logic [CNT_WIDTH-1:0] stall_cyc_q, stall_cyc_d;
    logic [CNT_WIDTH-1:0] flush_ev_q, flush_ev_d;

    logic       lw_stall_s;
    logic       mem_wait_s;
    logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic       flush_d_s, flush_e_s, flush_w_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // Forward select for one ALU operand; M wins over W, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Raw hazard terms from the current pipeline contents.
    always_comb begin
        lw_stall_s = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        mem_wait_s = hz.MemReqM && !hz.MemReadyM;
    end

    // Operand forwarding, forced to register-file source while in reset.
    always_comb begin
        if (!rst_n) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else begin
            fwd_a_s = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
            fwd_b_s = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
        end
    end

    // Memory-wait FSM next state and watchdog counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = {WCW{1'b0}};
        case (state_q)
            ST_RUN: begin
                if (mem_wait_s) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCW'(1);
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (!mem_wait_s) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == FIRE_AT) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Stall/flush controls in priority order: error, memory wait, redirect, load-use.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        if (!rst_n) begin
            stall_f_s = 1'b0;
        end else if ((state_q == ST_ERROR) || mem_wait_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (hz.PCSrcE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (lw_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
        end
    end

    // Sticky error flag and saturating performance counters.
    always_comb begin
        mem_err_d = mem_err_q | (state_d == ST_ERROR);
        if (stall_f_s && (stall_cyc_q != CNT_MAX)) begin
            stall_cyc_d = stall_cyc_q + CNT_WIDTH'(1);
        end else begin
            stall_cyc_d = stall_cyc_q;
        end
        if ((flush_d_s || flush_e_s) && (flush_ev_q != CNT_MAX)) begin
            flush_ev_d = flush_ev_q + CNT_WIDTH'(1);
        end else begin
            flush_ev_d = flush_ev_q;
        end
    end

    // State, watchdog, error flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= {WCW{1'b0}};
            mem_err_q   <= 1'b0;
            stall_cyc_q <= {CNT_WIDTH{1'b0}};
            flush_ev_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cyc_q <= stall_cyc_d;
            flush_ev_q  <= flush_ev_d;
        end
    end

    assign hz.StallF      = stall_f_s;
    assign hz.StallD      = stall_d_s;
    assign hz.StallE      = stall_e_s;
    assign hz.StallM      = stall_m_s;
    assign hz.FlushD      = flush_d_s;
    assign hz.FlushE      = flush_e_s;
    assign hz.FlushW      = flush_w_s;
    assign hz.ForwardAE   = fwd_a_s;
    assign hz.ForwardBE   = fwd_b_s;
    assign hz.MemErr      = mem_err_q;
    assign hz.StallCycles = stall_cyc_q;
    assign hz.FlushEvents = flush_ev_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (CNT_WIDTH=4, MEM_TIMEOUT=4).
// Stimulus pushes one expected record per cycle; the monitor pops and
// compares at the falling edge (or on demand for the async-reset check).
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.CNT_WIDTH(4)) hif ();

    hazard_ctrl #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    typedef struct {
        string      nm;
        logic [3:0] st;   // {StallF,StallD,StallE,StallM}
        logic [2:0] fl;   // {FlushD,FlushE,FlushW}
        logic [1:0] fa;
        logic [1:0] fb;
        logic       me;
        logic       cc;   // compare counters
        logic [3:0] sc;
        logic [3:0] fe;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: pop one expectation and compare against the DUT outputs.
    always @(negedge clk or chk_ev) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "stall", {hif.StallF, hif.StallD, hif.StallE, hif.StallM}, e.st);
            chk(e.nm, "flush", {1'b0, hif.FlushD, hif.FlushE, hif.FlushW}, {1'b0, e.fl});
            chk(e.nm, "fwdA", {2'b00, hif.ForwardAE}, {2'b00, e.fa});
            chk(e.nm, "fwdB", {2'b00, hif.ForwardBE}, {2'b00, e.fb});
            chk(e.nm, "memerr", {3'b000, hif.MemErr}, {3'b000, e.me});
            if (e.cc) begin
                chk(e.nm, "stallcyc", hif.StallCycles, e.sc);
                chk(e.nm, "flushev", hif.FlushEvents, e.fe);
            end
        end
    end

    task automatic drive(input logic [4:0] rs1d, input logic [4:0] rs2d,
                         input logic [4:0] rs1e, input logic [4:0] rs2e,
                         input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                         input logic [1:0] rsrc, input logic rwm, input logic rww,
                         input logic pcs, input logic mreq, input logic mrdy);
        hif.Rs1D = rs1d; hif.Rs2D = rs2d; hif.Rs1E = rs1e; hif.Rs2E = rs2e;
        hif.RdE = rde; hif.RdM = rdm; hif.RdW = rdw; hif.ResultSrcE = rsrc;
        hif.RegWriteM = rwm; hif.RegWriteW = rww; hif.PCSrcE = pcs;
        hif.MemReqM = mreq; hif.MemReadyM = mrdy;
    endtask

    task automatic push(input string nm, input logic [3:0] st, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic me,
                        input logic cc, input logic [3:0] sc, input logic [3:0] fe);
        exp_t e;
        e.nm = nm; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb;
        e.me = me; e.cc = cc; e.sc = sc; e.fe = fe;
        sb.push_back(e);
    endtask

    // One cycle: new inputs just after the rising edge, then its expectation.
    task automatic step(input string nm,
                        input logic [4:0] rs1d, input logic [4:0] rs2d,
                        input logic [4:0] rs1e, input logic [4:0] rs2e,
                        input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                        input logic [1:0] rsrc, input logic rwm, input logic rww,
                        input logic pcs, input logic mreq, input logic mrdy,
                        input logic [3:0] st, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic me,
                        input logic cc, input logic [3:0] sc, input logic [3:0] fe);
        @(posedge clk);
        #1;
        drive(rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rsrc, rwm, rww, pcs, mreq, mrdy);
        push(nm, st, fl, fa, fb, me, cc, sc, fe);
    endtask

    initial begin
        int wait_cyc;
        // Reset with a forwarding match present: outputs must still be zero.
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        push("reset", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0, 4'd0);
        -> chk_ev;
        #1;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #9 rst_n = 1'b1;

        //    name          rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   rsrc  rwm  rww  pcs  mreq mrdy  stall    flush   fa     fb     me   cc   sc    fe
        step("fwd_m",       5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b10,2'b00,1'b0,1'b1,4'd0, 4'd0);
        step("fwd_w",       5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b01,2'b00,1'b0,1'b1,4'd0, 4'd0);
        step("fwd_x0",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd0, 4'd0);
        step("fwd_b",       5'd0, 5'd0, 5'd9, 5'd7, 5'd0, 5'd7, 5'd9, 2'b00,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b01,2'b10,1'b0,1'b1,4'd0, 4'd0);
        step("lw_stall",    5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b01,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1100,3'b010,2'b00,2'b00,1'b0,1'b1,4'd0, 4'd0);
        step("lw_after",    5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd1, 4'd1);
        step("lw_x0",       5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd1, 4'd1);
        step("redir_lw",    5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b01,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b0000,3'b110,2'b00,2'b00,1'b0,1'b1,4'd1, 4'd1);
        step("redir_after", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd1, 4'd2);
        step("mwait1_pc",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b1,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd1, 4'd2);
        step("mwait2",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd2, 4'd2);
        step("mwait3",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd3, 4'd2);
        step("mem_ready",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b1, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd4, 4'd2);
        step("mem_done",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd4, 4'd2);
        // Timeout: six wait cycles, error visible from the fifth.
        step("tmo1",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd4, 4'd2);
        step("tmo2",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd5, 4'd2);
        step("tmo3",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd6, 4'd2);
        step("tmo4",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd7, 4'd2);
        step("tmo5",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b1,1'b1,4'd8, 4'd2);
        step("tmo6",        5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b1,1'b1,4'd9, 4'd2);
        step("err_ready",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b1, 4'b1111,3'b001,2'b00,2'b00,1'b1,1'b1,4'd10,4'd2);
        step("err_pc",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b1,1'b1,4'd11,4'd2);

        // Asynchronous reset in mid-cycle clears everything at once.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        push("async_rst", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0, 4'd0);
        -> chk_ev;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;

        step("post_rst",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd0, 4'd0);
        step("rst_mwait",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b1,1'b0, 4'b1111,3'b001,2'b00,2'b00,1'b0,1'b1,4'd0, 4'd0);
        step("rst_idle",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd1, 4'd0);

        // Saturation: 20 load-use cycles drive both counters to 4'hF.
        for (int k = 0; k < 20; k++) begin
            logic [3:0] sc_e;
            logic [3:0] fe_e;
            sc_e = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            fe_e = (k > 15) ? 4'd15 : 4'(k);
            step("sat",     5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 2'b01,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1100,3'b010,2'b00,2'b00,1'b0,1'b1,sc_e, fe_e);
        end
        step("sat_hold",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000,3'b000,2'b00,2'b00,1'b0,1'b1,4'd15,4'd15);

        wait_cyc = 0;
        while ((sb.size() > 0) && (wait_cyc < 20)) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_chk++;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32 core. It drives the stall, flush and forwarding controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, branch/jump redirects and multi-cycle data-memory waits. It also runs a memory-wait watchdog and two saturating performance counters.

## Interface
- `CNT_WIDTH`, 32, width of performance counters
- `MEM_TIMEOUT`, 64, maximum consecutive memory-wait cycles before error (≥1)
- `clk` input 1 — rising-edge clock
- `rst_n` input 1 — reset, asynchronous, active-low
- `Rs1D`, `Rs2D` input 5 — source registers of the instruction in D
- `Rs1E`, `Rs2E` input 5 — source registers of the instruction in E
- `RdE`, `RdM`, `RdW` input 5 — destination registers in E/M/W
- `ResultSrcE` input 2 — `2'b01` means the instruction in E is a load
- `RegWriteM`, `RegWriteW` input 1 — register write enables in M/W
- `PCSrcE` input 1 — taken branch, jal or jalr resolved in E
- `MemReqM` input 1 — the instruction in M accesses data memory
- `MemReadyM` input 1 — data memory completes the access this cycle
- `StallF`, `StallD`, `StallE`, `StallM` output 1 — hold the PC and the IF/ID, ID/EX and EX/MEM registers
- `FlushD`, `FlushE`, `FlushW` output 1 — insert a bubble into IF/ID, ID/EX and MEM/WB
- `ForwardAE`, `ForwardBE` output 2 — ALU operand select: `00` register file, `10` M result, `01` W result
- `MemErr` output 1 — sticky memory-timeout error
- `StallCycles` output CNT_WIDTH — count of cycles with `StallF` high
- `FlushEvents` output CNT_WIDTH — count of cycles with `FlushD` or `FlushE` high

## Operation
**Forwarding (combinational)**
- `ForwardAE=10` if `RegWriteM && RdM!=0 && RdM==Rs1E`.
- Otherwise `01` if `RegWriteW && RdW!=0 && RdW==Rs1E`.
- Otherwise `00`.
- `ForwardBE` uses the same rule with `Rs2E`. M has priority over W.

**Hazard terms**
- `lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)`.
- `memWait = MemReqM && !MemReadyM`.

**FSM states:** RUN, WAIT, ERROR.
- RUN → WAIT when `memWait`. WAIT → RUN when `!memWait`.
- WAIT → ERROR when `memWait` holds and the wait counter equals `MEM_TIMEOUT-1`.
- ERROR is absorbing until reset.
- Wait counter: cleared in RUN, incremented each cycle in WAIT.

**Output priority**, evaluated combinationally from state and inputs:
1. **ERROR:** Stall F/D/E/M=1, FlushW=1, FlushD=FlushE=0, MemErr=1.
2. **`memWait`** (in RUN or WAIT): Stall F/D/E/M=1, FlushW=1, FlushD=FlushE=0. This freezes the whole pipeline. A pending `PCSrcE` is held in E and acted on after the wait ends.
3. **`PCSrcE`:** FlushD=FlushE=1, all stalls 0. The redirect wins over a simultaneous `lwStall`.
4. **`lwStall`:** StallF=StallD=1, FlushE=1, others 0. This gives exactly one bubble, because the load advances to M on the next edge.
5. **Otherwise:** all stall and flush outputs are 0.

**Counters**
- Registered and saturating at all-ones. They never wrap.
- Both may increment in the same cycle.

## Timing
- Forwarding, stall and flush outputs are combinational: zero-cycle latency from their inputs and from registered state.
- State, wait counter, `MemErr` and the performance counters update on the rising edge of `clk`.
- Reset (`rst_n` low) acts immediately and independently of `clk`. It sets state=RUN, wait counter=0, `MemErr`=0, `StallCycles`=0, `FlushEvents`=0.
- While `rst_n` is low, every stall, flush and forward output is forced to 0.
- Reset during WAIT or ERROR returns the block to RUN immediately.
- `MemReadyM` high in the same cycle as `MemReqM` means no wait: the state stays RUN.
- The timeout fires on the `MEM_TIMEOUT`-th consecutive `memWait` cycle. `MemErr` rises on the following edge.
- With `MEM_TIMEOUT=1`, a single `memWait` cycle goes RUN → WAIT. The transition to ERROR follows on the next cycle if `memWait` persists.
- Register x0 never causes forwarding or a load-use stall.

## Test plan
- **Forwarding:** `RegWriteM=1`, `RdM=5`, `RegWriteW=1`, `RdW=5`, `Rs1E=5`, `Rs2E=0` → `ForwardAE=10`, `ForwardBE=00`. Then drop `RegWriteM` → `ForwardAE=01`.
- **Load-use:** `ResultSrcE=01`, `RdE=3`, `Rs2D=3` → StallF=StallD=FlushE=1 for exactly one cycle, and `StallCycles` increments by 1. Repeat with `RdE=0` → no stall.
- **Redirect vs load-use:** `PCSrcE=1` together with `lwStall` → FlushD=FlushE=1, StallF=0, and `FlushEvents` increments by 1.
- **Memory wait:** `MemReqM=1`, `MemReadyM=0` for 3 cycles, then ready → all stalls and FlushW high for 3 cycles, state returns to RUN, and `StallCycles` increments by 3.
- **Timeout:** `MEM_TIMEOUT=4`, hold `memWait` for 6 cycles → `MemErr=1` from the edge after the 4th cycle and stays set after `MemReadyM=1`. Asynchronous `rst_n` low mid-cycle clears `MemErr` and the counters immediately.
- **Saturation:** with `CNT_WIDTH=4`, stall for 20 cycles → `StallCycles=15` (4'hF) and holds there.
